// File: rtl/tetris_input_sched.sv
// Input scheduler for the tetris grid: debounces the buttons, turns the joystick into
// left/right with auto-repeat, times gravity from the level and issues one move at a time.
module tetris_input_sched #(
  parameter int unsigned DEBOUNCE_CYC  = 500_000,
  parameter int unsigned DAS_DELAY     = 8_000_000,
  parameter int unsigned DAS_REPEAT    = 2_000_000,
  parameter int unsigned GRAV_BASE     = 40_000_000,
  parameter int unsigned GRAV_STEP     = 3_000_000,
  parameter int unsigned GRAV_MIN      = 4_000_000,
  parameter int unsigned SOFT_DROP     = 8_000_000,
  parameter int unsigned ADC_LO        = 1024,
  parameter int unsigned ADC_HI        = 3072,
  parameter int unsigned LINES_PER_LVL = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] adc_x,
  input  logic        rotate_btn,
  input  logic        drop_btn,
  input  logic        row_cleared,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd,
  output logic [3:0]  level,
  output logic [7:0]  lines
);

  // state   | meaning
  // S_IDLE  | game stopped, counters and pending flags held at 0
  // S_RUN   | collecting events, picks the highest-priority pending move
  // S_ISSUE | cmd_valid high, cmd held until the grid takes it
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ISSUE} state_t;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_L    = 2'd1;
  localparam logic [1:0] DIR_R    = 2'd2;

  state_t      state;
  logic [1:0]  rot_sync, drop_sync;
  logic        rot_deb, drop_deb, rot_deb_q;
  logic [31:0] rot_db_cnt, drop_db_cnt;
  logic [1:0]  dir, dir_q;
  logic [31:0] das_cnt, grav_cnt, grav_p, lvl_red, sub_cnt;
  logic [3:0]  pend, pend_n;
  logic        lr_new, lr_ev, ev_l, ev_r, rot_ev, ev_dn, hs;

  // debounce counters count down the remaining stable cycles; reload whenever input matches
  always_ff @(posedge clk) begin
    if (reset) begin
      rot_sync    <= '0;
      drop_sync   <= '0;
      rot_deb     <= 1'b0;
      drop_deb    <= 1'b0;
      rot_deb_q   <= 1'b0;
      rot_db_cnt  <= '0;
      drop_db_cnt <= '0;
    end else begin
      rot_sync  <= {rot_sync[0], rotate_btn};
      drop_sync <= {drop_sync[0], drop_btn};
      rot_deb_q <= rot_deb;
      if (rot_sync[1] == rot_deb) rot_db_cnt <= DEBOUNCE_CYC - 1;
      else if (rot_db_cnt == 0) begin
        rot_deb    <= rot_sync[1];
        rot_db_cnt <= DEBOUNCE_CYC - 1;
      end else rot_db_cnt <= rot_db_cnt - 1;
      if (drop_sync[1] == drop_deb) drop_db_cnt <= DEBOUNCE_CYC - 1;
      else if (drop_db_cnt == 0) begin
        drop_deb    <= drop_sync[1];
        drop_db_cnt <= DEBOUNCE_CYC - 1;
      end else drop_db_cnt <= drop_db_cnt - 1;
    end
  end

  always_comb begin
    dir = DIR_NONE;
    if (32'(adc_x) < ADC_LO)      dir = DIR_L;
    else if (32'(adc_x) > ADC_HI) dir = DIR_R;
  end

  assign lr_new = (dir != DIR_NONE) && (dir != dir_q);
  assign lr_ev  = lr_new || ((dir != DIR_NONE) && (das_cnt == 0));
  assign ev_l   = lr_ev && (dir == DIR_L);
  assign ev_r   = lr_ev && (dir == DIR_R);
  assign rot_ev = rot_deb && !rot_deb_q;

  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) begin
      dir_q   <= DIR_NONE;
      das_cnt <= '0;
    end else begin
      dir_q <= dir;
      if (lr_new)                das_cnt <= DAS_DELAY - 1;
      else if (dir == DIR_NONE)  das_cnt <= '0;
      else if (das_cnt == 0)     das_cnt <= DAS_REPEAT - 1;
      else                       das_cnt <= das_cnt - 1;
    end
  end

  // subtract only when it cannot drop below the floor, so the period never underflows
  assign lvl_red = 32'(level) * GRAV_STEP;
  always_comb begin
    grav_p = GRAV_MIN;
    if (GRAV_BASE > lvl_red && (GRAV_BASE - lvl_red) > GRAV_MIN) grav_p = GRAV_BASE - lvl_red;
    if (drop_deb && SOFT_DROP < grav_p) grav_p = SOFT_DROP;
  end

  assign ev_dn = (state != S_IDLE) && (grav_cnt >= grav_p - 1);

  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) grav_cnt <= '0;
    else if (ev_dn)               grav_cnt <= '0;
    else                          grav_cnt <= grav_cnt + 1;
  end

  // pend bit index equals the command code it requests
  assign hs = (state == S_ISSUE) && cmd_valid && cmd_ready;
  always_comb begin
    pend_n = pend;
    if (hs) pend_n[cmd] = 1'b0;
    if (ev_l) begin
      pend_n[0] = 1'b1;
      pend_n[1] = 1'b0;
    end
    if (ev_r) begin
      pend_n[1] = 1'b1;
      pend_n[0] = 1'b0;
    end
    if (rot_ev) pend_n[2] = 1'b1;
    if (ev_dn)  pend_n[3] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_valid <= 1'b0;
      cmd       <= 2'd0;
      pend      <= '0;
    end else if (!enable) begin
      state     <= S_IDLE;
      cmd_valid <= 1'b0;
      pend      <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_RUN;
        S_RUN: begin
          pend <= pend_n;
          if (|pend) begin
            if (pend[3])      cmd <= 2'd3;
            else if (pend[2]) cmd <= 2'd2;
            else if (pend[1]) cmd <= 2'd1;
            else              cmd <= 2'd0;
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          pend <= pend_n;
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lines   <= '0;
      level   <= '0;
      sub_cnt <= '0;
    end else if (row_cleared) begin
      if (lines != 8'd255) lines <= lines + 8'd1;
      if (sub_cnt == LINES_PER_LVL - 1) begin
        sub_cnt <= '0;
        if (level != 4'd9) level <= level + 4'd1;
      end else sub_cnt <= sub_cnt + 1;
    end
  end

endmodule

// File: tb/tb_tetris_input_sched.sv
// Directed bench for tetris_input_sched with shrunk timing parameters.
module tb_tetris_input_sched;

  logic        clk = 1'b0;
  logic        reset, enable, rotate_btn, drop_btn, row_cleared, cmd_ready;
  logic [11:0] adc_x;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [3:0]  level;
  logic [7:0]  lines;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  tetris_input_sched #(
    .DEBOUNCE_CYC(4), .DAS_DELAY(20), .DAS_REPEAT(5), .GRAV_BASE(100), .GRAV_STEP(10),
    .GRAV_MIN(30), .SOFT_DROP(40), .ADC_LO(1024), .ADC_HI(3072), .LINES_PER_LVL(10)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_x(adc_x), .rotate_btn(rotate_btn),
    .drop_btn(drop_btn), .row_cleared(row_cleared), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd(cmd), .level(level), .lines(lines)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic restart();
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 enable = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cmd_valid) cnt++;
    end
  endtask

  task automatic pulse_rows(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 row_cleared = 1'b1;
      @(posedge clk); #1 row_cleared = 1'b0;
    end
  endtask

  int c0, a1, a2, cnt, rot_cmd;
  int hits[$];
  int exp_t[5];

  initial begin
    exp_t = '{2, 22, 27, 32, 37};
    reset = 1'b1; enable = 1'b0; adc_x = 12'd2048; rotate_btn = 1'b0;
    drop_btn = 1'b0; row_cleared = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_level", level, 0);
    chk("rst_lines", lines, 0);
    @(posedge clk); #1 reset = 1'b0;

    // gravity alone at level 0: one-cycle down command every 100 cycles
    restart(); c0 = cyc;
    wait_valid(200, a1);
    chk("grav_first", a1, c0 + 102);
    chk("grav_cmd", cmd, 3);
    @(negedge clk);
    chk("grav_width", cmd_valid, 0);
    wait_valid(200, a2);
    chk("grav_period", a2 - a1, 100);

    // left held: first event immediately, then after delay, then repeats
    restart();
    @(posedge clk); #1 adc_x = 12'd500;
    hits.delete();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (cmd_valid) begin
        hits.push_back(t);
        chk("left_cmd", cmd, 0);
      end
    end
    chk("left_count", hits.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < hits.size()) chk("left_time", hits[k], exp_t[k]);
    @(posedge clk); #1 adc_x = 12'd2048;
    count_valid(30, cnt);
    chk("center_none", cnt, 0);
    @(posedge clk); #1 adc_x = 12'd1024;
    count_valid(20, cnt);
    chk("adc_lo_edge", cnt, 0);

    // right boundary
    restart();
    @(posedge clk); #1 adc_x = 12'd3072;
    count_valid(10, cnt);
    chk("adc_hi_edge", cnt, 0);
    @(posedge clk); #1 adc_x = 12'd3073; c0 = cyc;
    wait_valid(10, a1);
    chk("right_lat", a1, c0 + 2);
    chk("right_cmd", cmd, 1);
    @(posedge clk); #1 adc_x = 12'd2048;

    // rotate glitch rejected, held press gives exactly one rotate
    restart();
    @(posedge clk); #1 rotate_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 rotate_btn = 1'b0;
    count_valid(20, cnt);
    chk("rot_glitch", cnt, 0);
    cnt = 0; rot_cmd = -1;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1 rotate_btn = (t < 10);
      @(negedge clk);
      if (cmd_valid) begin
        cnt++;
        rot_cmd = cmd;
      end
    end
    chk("rot_once", cnt, 1);
    chk("rot_cmd", rot_cmd, 2);

    // stalled grid: down then rotate pending, down holds first
    cmd_ready = 1'b0;
    restart();
    repeat (97) @(posedge clk);
    #1 rotate_btn = 1'b1;
    repeat (12) @(posedge clk);
    #1 rotate_btn = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stall_valid", cmd_valid, 1);
    chk("stall_cmd", cmd, 3);
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(negedge clk);
    chk("hs_cmd", cmd, 3);
    @(negedge clk);
    chk("gap_valid", cmd_valid, 0);
    @(negedge clk);
    chk("next_valid", cmd_valid, 1);
    chk("next_cmd", cmd, 2);
    @(negedge clk);
    chk("next_done", cmd_valid, 0);

    // levels and gravity period
    pulse_rows(25);
    @(negedge clk);
    chk("lines_25", lines, 25);
    chk("level_2", level, 2);
    restart(); c0 = cyc;
    wait_valid(120, a1);
    chk("period_lvl2", a1, c0 + 82);
    @(posedge clk); #1 drop_btn = 1'b1;
    repeat (10) @(posedge clk);
    restart(); c0 = cyc;
    wait_valid(120, a1);
    chk("soft_first", a1, c0 + 42);
    wait_valid(120, a2);
    chk("soft_period", a2 - a1, 40);
    @(posedge clk); #1 drop_btn = 1'b0;
    repeat (10) @(posedge clk);
    pulse_rows(95);
    @(negedge clk);
    chk("lines_120", lines, 120);
    chk("level_sat", level, 9);
    restart(); c0 = cyc;
    wait_valid(120, a1);
    chk("period_min", a1, c0 + 32);
    pulse_rows(140);
    @(negedge clk);
    chk("lines_sat", lines, 255);

    // enable abort mid-handshake, then reset mid-handshake
    cmd_ready = 1'b0;
    restart(); c0 = cyc;
    wait_valid(60, a1);
    chk("abort_setup", a1, c0 + 32);
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_valid", cmd_valid, 0);
    chk("abort_lines", lines, 255);
    chk("abort_level", level, 9);
    @(posedge clk); #1 cmd_ready = 1'b1; enable = 1'b1;
    count_valid(20, cnt);
    chk("abort_flags", cnt, 0);
    @(posedge clk); #1 cmd_ready = 1'b0;
    wait_valid(60, a1);
    chk("rst_setup", cmd_valid, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_valid", cmd_valid, 0);
    chk("rst2_cmd", cmd, 0);
    chk("rst2_level", level, 0);
    chk("rst2_lines", lines, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tetris_input_sched.md
Name: tetris_input_sched

Overview:
Input scheduler and gravity controller in front of the tetris grid engine. It debounces the rotate/drop buttons and decodes the joystick ADC into left/right with delayed auto-repeat. It times gravity steps from the current level, arbitrates all pending move requests and issues them one at a time to the grid over a valid/ready command handshake.

Parameters:
DEBOUNCE_CYC, 500_000, consecutive stable cycles before a button's debounced level changes
DAS_DELAY, 8_000_000, cycles a direction is held before auto-repeat starts
DAS_REPEAT, 2_000_000, cycles between auto-repeat requests
GRAV_BASE, 40_000_000, gravity period at level 0
GRAV_STEP, 3_000_000, period reduction per level
GRAV_MIN, 4_000_000, gravity period floor
SOFT_DROP, 8_000_000, gravity period while drop is held (used only if shorter than the level period)
ADC_LO, 1024, adc_x below this value decodes as left
ADC_HI, 3072, adc_x above this value decodes as right
LINES_PER_LVL, 10, cleared rows per level increment

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  game running; low aborts and idles the block
adc_x  in  12  joystick X sample
rotate_btn  in  1  raw rotate button, asynchronous, 2-flop synchronised internally
drop_btn  in  1  raw soft-drop button, asynchronous, 2-flop synchronised internally
row_cleared  in  1  one-cycle pulse per cleared row, from the grid
cmd_ready  in  1  grid accepts the command this cycle
cmd_valid  out  1  command offered
cmd  out  2  00 left, 01 right, 10 rotate, 11 down
level  out  4  current level, 0..9
lines  out  8  total cleared rows, saturates at 255

Behaviour:
- Reset values: all outputs 0, FSM in S_IDLE, all counters and pending flags 0, debounced levels 0.
- Debounce: each button has its own counter. The counter resets whenever the synchronised input equals the debounced level. The debounced level flips once the input has differed for DEBOUNCE_CYC consecutive cycles.
- Rotate event: rising edge of the debounced rotate level. Holding the button produces no repeat.
- Horizontal decode: dir = L if adc_x < ADC_LO, R if adc_x > ADC_HI, else none. Boundary values (== ADC_LO, == ADC_HI) decode as none.
- Auto-repeat: when dir changes to L or R, one event fires the same cycle and the DAS counter restarts. After DAS_DELAY cycles held, the next event fires, then one every DAS_REPEAT cycles. Changing or releasing dir restarts the sequence.
- Gravity period: P = max(GRAV_BASE - level*GRAV_STEP, GRAV_MIN). If debounced drop is high, P = min(P, SOFT_DROP). The gravity counter counts 0..P-1; on reaching P-1 it raises a down event and wraps to 0. If P shrinks below the current count, the event fires next cycle.
- Pending flags: pend_l, pend_r, pend_rot, pend_dn are set by events. An event on an already-set flag is merged (no queueing). An L event clears pend_r, and an R event clears pend_l. An event arriving in the same cycle as a handshake of the same type sets the flag again.
- FSM states:
  - S_IDLE: enable = 0. Counters held at 0, flags cleared, cmd_valid = 0. Goes to S_RUN when enable = 1.
  - S_RUN: if any flag is set, latch the highest priority into cmd and go to S_ISSUE. Priority: down > rotate > left/right.
  - S_ISSUE: cmd_valid = 1 and cmd stays stable until cmd_ready. On cmd_valid & cmd_ready, clear that flag and return to S_RUN, so cmd_valid is low for at least one cycle between commands.
- Latency: an event in cycle N with no pending work gives cmd_valid in cycle N+2.
- enable falling in any state: go to S_IDLE next cycle and drop cmd_valid even without a handshake. This is the one permitted abort. lines and level are kept; only reset clears them.
- Levels: row_cleared increments lines (saturating at 255) and a sub-counter. When the sub-counter reaches LINES_PER_LVL it wraps to 0 and level increments, saturating at 9.
- Reset asserted mid-handshake: all outputs return to 0 on the next edge.

Test Plan:
1. Run with small parameters (DEBOUNCE_CYC=4, DAS_DELAY=20, DAS_REPEAT=5, GRAV_BASE=100, GRAV_STEP=10, GRAV_MIN=30, SOFT_DROP=40). Pulse reset, then enable=1, cmd_ready=1, no input -> cmd=11 with cmd_valid every 100 cycles, one cycle wide.
2. adc_x=500 held for 40 cycles with cmd_ready=1 -> left commands at t≈2, 22, 27, 32, 37. Setting adc_x=2048 stops commands, and adc_x=1024 also yields none.
3. rotate_btn glitch of 3 cycles -> no command. Held for 10 cycles -> exactly one cmd=10.
4. cmd_ready=0 with a down and a rotate event pending -> cmd=11 held stable. After ready, cmd_valid drops for 1 cycle, then cmd=10 is issued.
5. 25 row_cleared pulses -> lines=25, level=2, gravity period 80. drop_btn held -> period 40. After 95 more pulses -> level=9 (saturated), period=30.
6. Drop enable while cmd_valid=1 and cmd_ready=0 -> cmd_valid=0 the next cycle, flags cleared, lines retained. Assert reset -> all outputs 0.
